maxunpool1d: RTL
================

Name: maxunpool1d

Overview:
- Streaming 1-D max-unpool: the inverse of the 1-D max-pool blocks in the pooling_layers library.
- Each accepted input beat carries P pooled values plus their argmax window offsets.
- Emits KERNEL_SIZE output beats that rebuild the un-pooled tensor in order: each pooled value goes back to its argmax position, and every other position is zero.
- Sits in decoder / upsampling paths, fed by a pooled-value stream and an index stream that share one handshake.

Parameters:
- DATA_IN_0_PRECISION_0, 8, total bit width of a pooled value.
- DATA_IN_0_PRECISION_1, 3, fractional bits of a pooled value; passed through unchanged.
- DATA_IN_0_TENSOR_SIZE_DIM_0, 4, pooled tensor length.
- DATA_IN_0_PARALLELISM_DIM_0, 1, lanes per beat (P); must divide DATA_IN_0_TENSOR_SIZE_DIM_0.
- KERNEL_SIZE, 2, window size K; stride is fixed equal to K (non-overlapping windows); K >= 2.
- DATA_IN_1_PRECISION_0, $clog2(KERNEL_SIZE), index width; minimum 1.
- DATA_OUT_0_PRECISION_0, 8, must equal DATA_IN_0_PRECISION_0.
- DATA_OUT_0_PRECISION_1, 3, must equal DATA_IN_0_PRECISION_1.
- DATA_OUT_0_TENSOR_SIZE_DIM_0, 8, must equal DATA_IN_0_TENSOR_SIZE_DIM_0*K.
- DATA_OUT_0_PARALLELISM_DIM_0, 1, must equal DATA_IN_0_PARALLELISM_DIM_0.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- data_in_0, input, [PREC_0-1:0] x P (unpacked), pooled values; lane i = pooled element beat*P+i.
- data_in_1, input, [DATA_IN_1_PRECISION_0-1:0] x P (unpacked), argmax offset within each lane's window.
- data_in_0_valid, input, 1, data_in_0 and data_in_1 both valid.
- data_in_0_ready, output, 1, block accepts both inputs this cycle.
- data_out_0, output, [PREC_0-1:0] x P (unpacked), un-pooled values.
- data_out_0_valid, output, 1, output beat valid.
- data_out_0_ready, input, 1, downstream accepts the beat.

Behaviour:
- Storage: one holding register (P values + P indices), flag buf_valid, beat counter cnt in [0,K-1].
- Two states:
  - EMPTY (buf_valid=0).
  - EMIT (buf_valid=1).
- Reset (rst=1 at a clock edge): buf_valid=0, cnt=0, holding register cleared to 0. After reset: data_out_0_valid=0, data_out_0 all zero, data_in_0_ready=1. Reset mid-burst discards the buffered beat and any remaining output beats.
- Input acceptance: accept = data_in_0_valid & data_in_0_ready.
- data_in_0_ready = !buf_valid | (data_out_0_ready & cnt==K-1). This is combinational from data_out_0_ready, so a new input can load on the same edge the last output beat retires.
- On accept: load the holding register, set buf_valid=1, set cnt=0.
- data_out_0_valid = buf_valid.
- data_out_0 is combinational from the holding register and cnt, and is all zero when buf_valid=0.
- Output mapping, beat b=cnt, lane l:
  - q = b*P + l; src = q / K; off = q % K.
  - data_out_0[l] = (idx[src]==off) ? val[src] : 0.
  - src and off are compile-time per (b,l); implement as a mux on cnt.
- On output handshake (valid & ready):
  - if cnt < K-1: cnt increments.
  - if cnt == K-1: cnt=0, and buf_valid = accept (a new beat loaded on this edge keeps buf_valid=1).
- Stall: with data_out_0_ready=0, data_out_0, valid and cnt hold stable.
- Latency: first output beat is valid in the cycle after the accept edge.
- Throughput: one input beat per K cycles when downstream never stalls; output valid stays continuously high across back-to-back inputs.
- Index out of range (idx >= K): that lane's value never matches, so all its output positions are 0. No error flag.
- Arithmetic: none. Values pass bit-exact; zero is the all-zero word.
- Elaboration-time assertions: precision equality, output tensor size = input size * K, output parallelism = input parallelism.

Test Plan:
- Reset: hold rst 3 cycles with data_in_0_valid=1 -> data_out_0_valid=0 and data_in_0_ready=1 throughout; nothing is accepted during reset.
- Basic (P=1, K=2, out ready always): inputs (val,idx) = (0x15,1),(0x7F,0),(0x80,1),(0x01,0) -> output stream 0x00,0x15,0x7F,0x00,0x00,0x80,0x01,0x00; data_in_0_ready high every 2nd cycle; output valid continuous.
- Lane remap (P=2, K=2): val={L0=0x11,L1=0x22}, idx={1,0} -> beat0 = {0x00,0x11}, beat1 = {0x22,0x00}.
- Backpressure: deassert data_out_0_ready for 5 cycles mid-beat -> data_out_0 and cnt frozen, data_in_0_ready=0, no beat lost or duplicated.
- Boundary (K=3): idx=3 on val 0x40 -> three zero beats. Then assert rst while cnt=1 -> output valid drops on the next cycle and the next accepted input restarts at cnt=0.
- Back-to-back (P=1, K=2): input valid held with new data every accept -> an accept coincides with every second output handshake; no idle cycle on data_out_0_valid.

Source files
------------

// File: rtl/maxunpool1d.sv
// maxunpool1d: streaming 1-D max-unpool, each pooled beat expands into KERNEL_SIZE output beats.
module maxunpool1d #(
  parameter int DATA_IN_0_PRECISION_0        = 8,
  parameter int DATA_IN_0_PRECISION_1        = 3,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0  = 1,
  parameter int KERNEL_SIZE                  = 2,
  parameter int DATA_IN_1_PRECISION_0        = $clog2(KERNEL_SIZE),
  parameter int DATA_OUT_0_PRECISION_0       = 8,
  parameter int DATA_OUT_0_PRECISION_1       = 3,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 8,
  parameter int DATA_OUT_0_PARALLELISM_DIM_0 = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0 [DATA_IN_0_PARALLELISM_DIM_0],
  input  logic [DATA_IN_1_PRECISION_0-1:0] data_in_1 [DATA_IN_0_PARALLELISM_DIM_0],
  input  logic                             data_in_0_valid,
  output logic                             data_in_0_ready,
  output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0],
  output logic                             data_out_0_valid,
  input  logic                             data_out_0_ready
);
  localparam int P  = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int K  = KERNEL_SIZE;
  localparam int W  = DATA_IN_0_PRECISION_0;
  localparam int IW = DATA_IN_1_PRECISION_0;
  localparam int CW = $clog2(K);
  if (DATA_OUT_0_PRECISION_0 != DATA_IN_0_PRECISION_0 || DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1)
    begin : g_bad_prec $error("maxunpool1d: output precision must match input precision"); end
  if (DATA_OUT_0_TENSOR_SIZE_DIM_0 != DATA_IN_0_TENSOR_SIZE_DIM_0 * KERNEL_SIZE)
    begin : g_bad_size $error("maxunpool1d: output tensor size must be input size * KERNEL_SIZE"); end
  if (DATA_OUT_0_PARALLELISM_DIM_0 != DATA_IN_0_PARALLELISM_DIM_0 || DATA_IN_0_TENSOR_SIZE_DIM_0 % P != 0)
    begin : g_bad_par $error("maxunpool1d: parallelism mismatch or does not divide tensor size"); end
  if (K < 2 || IW < 1)
    begin : g_bad_k $error("maxunpool1d: KERNEL_SIZE must be >= 2 and index width >= 1"); end
  typedef enum logic {EMPTY, EMIT} state_t;
  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   val [P];
  logic [IW-1:0]  idx [P];
  logic           last, accept;
  assign last             = cnt == CW'(K - 1);
  assign data_out_0_valid = state == EMIT;
  assign data_in_0_ready  = state == EMPTY || (data_out_0_ready && last);
  assign accept           = data_in_0_valid && data_in_0_ready;
  // Output position q = b*P+l belongs to window q/K at offset q%K; all constant per (b,l).
  always_comb begin
    for (int l = 0; l < P; l++) begin
      data_out_0[l] = '0;
      for (int b = 0; b < K; b++)
        if (data_out_0_valid && cnt == CW'(b) && idx[(b*P+l)/K] == IW'((b*P+l)%K))
          data_out_0[l] = val[(b*P+l)/K];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      cnt   <= '0;
      val   <= '{default: '0};
      idx   <= '{default: '0};
    end else begin
      if (data_out_0_valid && data_out_0_ready) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) state <= EMPTY;
      end
      if (accept) begin
        val   <= data_in_0;
        idx   <= data_in_1;
        cnt   <= '0;
        state <= EMIT;
      end
    end
  end
endmodule
